// File: rtl/mult_div_seq.sv
// Iterative MIPS multiply/divide unit owning HI/LO: radix-2 add-shift multiply,
// restoring divide, one bit per cycle, followed by a sign-fix cycle.
module mult_div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       MDOp,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             mthi,
    input  logic             mtlo,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX
    } state_t;

    state_t             r_state, w_next;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opb;
    logic               r_is_div, r_neg_q, r_neg_r;
    logic [WIDTH-1:0]   r_hi, r_lo;
    logic               r_busy, r_done, r_dbz;

    logic               w_signed, w_dbz;
    logic [WIDTH-1:0]   w_abs_a, w_abs_b, w_addend;
    logic [WIDTH:0]     w_mul_sum, w_div_sh, w_div_diff;
    logic               w_div_ok;
    logic [2*WIDTH-1:0] w_mul_next, w_div_next, w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix, w_rem_fix;

    assign w_signed = ~MDOp[0];
    assign w_dbz    = start & MDOp[1] & (B == '0);
    assign w_abs_a  = (w_signed & A[WIDTH-1]) ? -A : A;
    assign w_abs_b  = (w_signed & B[WIDTH-1]) ? -B : B;

    // Multiply: {partial, multiplier} shifts right; the carry lands in the top bit.
    assign w_addend   = r_acc[0] ? r_opb : '0;
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Divide: {remainder, dividend/quotient} shifts left; quotient bits enter at LSB.
    assign w_div_sh   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_div_diff = w_div_sh - {1'b0, r_opb};
    assign w_div_ok   = ~w_div_diff[WIDTH];
    assign w_div_next = {(w_div_ok ? w_div_diff[WIDTH-1:0] : w_div_sh[WIDTH-1:0]),
                         r_acc[WIDTH-2:0], w_div_ok};

    assign w_prod_fix = r_neg_q ? -r_acc : r_acc;
    assign w_quo_fix  = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem_fix  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start && !w_dbz) w_next = S_CALC;
            S_CALC:  if (r_cnt == '0) w_next = S_FIX;
            S_FIX:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != S_IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opb    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
            r_dbz    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_dbz  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_dbz) begin
                            r_done <= 1'b1;
                            r_dbz  <= 1'b1;
                        end else begin
                            r_is_div <= MDOp[1];
                            r_opb    <= MDOp[1] ? w_abs_b : w_abs_a;
                            r_acc    <= {{WIDTH{1'b0}}, (MDOp[1] ? w_abs_a : w_abs_b)};
                            r_neg_q  <= w_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                            r_neg_r  <= w_signed & A[WIDTH-1];
                            r_cnt    <= CNT_LAST;
                        end
                    end else begin
                        if (mthi) r_hi <= A;
                        if (mtlo) r_lo <= A;
                    end
                end
                S_CALC: begin
                    r_acc <= r_is_div ? w_div_next : w_mul_next;
                    r_cnt <= r_cnt - CW'(1);
                end
                S_FIX: begin
                    if (r_is_div) begin
                        r_hi <= w_rem_fix;
                        r_lo <= w_quo_fix;
                    end else begin
                        {r_hi, r_lo} <= w_prod_fix;
                    end
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign HI          = r_hi;
    assign LO          = r_lo;
    assign busy        = r_busy;
    assign done        = r_done;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_mult_div_seq.sv
// Scoreboard bench for mult_div_seq: stimulus pushes reference results computed
// with plain 64-bit arithmetic; a monitor pops and compares on every done pulse.
module tb_mult_div_seq;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   MDOp = 2'b00;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         mthi = 1'b0;
    logic         mtlo = 1'b0;
    logic [W-1:0] HI, LO;
    logic         busy, done, div_by_zero;

    mult_div_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .MDOp(MDOp), .A(A), .B(B),
        .mthi(mthi), .mtlo(mtlo), .HI(HI), .LO(LO), .busy(busy), .done(done),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        bit           dbz;
        int           cyc;
    } exp_t;

    exp_t         sbq[$];
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;
    int           n_cmp = 0;
    int           n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: architectural result from plain arithmetic; returns divide-by-zero.
    function automatic bit ref_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, svb, q, r;
        logic [63:0] p;
        sa  = $signed(a);
        svb = $signed(b);
        case (op)
            2'b00: begin p = sa * svb; {m_hi, m_lo} = p; end
            2'b01: begin p = {32'b0, a} * {32'b0, b}; {m_hi, m_lo} = p; end
            2'b10: begin
                if (b == 0) return 1'b1;
                q = sa / svb;
                r = sa % svb;
                m_lo = q[31:0];
                m_hi = r[31:0];
            end
            default: begin
                if (b == 0) return 1'b1;
                m_lo = a / b;
                m_hi = a % b;
            end
        endcase
        return 1'b0;
    endfunction

    exp_t mon_e;
    initial forever begin
        @(negedge clk);
        if (rst_n && done === 1'b1) begin
            if (sbq.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                mon_e = sbq.pop_front();
                chk("HI", HI, mon_e.hi);
                chk("LO", LO, mon_e.lo);
                chk("div_by_zero", div_by_zero, mon_e.dbz);
                chk("done_cycle", cyc, mon_e.cyc);
            end
        end
    end

    // Called at a negedge with the DUT idle; returns at the negedge of the done cycle.
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int intrude_at);
        exp_t e;
        int   s, n;
        bit   dz, got;
        MDOp  = op; A = a; B = b; start = 1'b1;
        dz    = ref_op(op, a, b);
        s     = cyc;
        e.hi  = m_hi; e.lo = m_lo; e.dbz = dz;
        e.cyc = s + (dz ? 1 : W + 2);
        sbq.push_back(e);
        @(negedge clk);
        start = 1'b0;
        got   = 1'b0;
        for (int i = 0; i < W + 8; i++) begin
            n = cyc - s;
            start = 1'b0; mthi = 1'b0;
            chk("busy", busy, (!dz && n >= 1 && n <= W + 1));
            if (done) begin got = 1'b1; break; end
            if (n == intrude_at) begin
                MDOp = 2'b11; A = 32'h0000AAAA; B = 32'd3; start = 1'b1; mthi = 1'b1;
            end
            @(negedge clk);
        end
        start = 1'b0; mthi = 1'b0;
        if (!got) chk("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic mt_write(input bit h, input bit l, input logic [31:0] a);
        mthi = h; mtlo = l; A = a;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0;
        if (h) m_hi = a;
        if (l) m_lo = a;
        chk("mt_HI", HI, m_hi);
        chk("mt_LO", LO, m_lo);
        chk("mt_done", done, 1'b0);
    endtask

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFFFFFF;
            3:       return 32'h80000000;
            4:       return 32'($urandom_range(0, 15));
            default: return $urandom();
        endcase
    endfunction

    initial begin
        int s;
        repeat (2) @(negedge clk);
        chk("rst_HI", HI, 0);
        chk("rst_LO", LO, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dbz", div_by_zero, 0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        do_op(2'b00, 32'hFFFFFFFD, 32'd7, 0);
        do_op(2'b00, 32'h80000000, 32'h80000000, 0);
        do_op(2'b10, 32'hFFFFFFF9, 32'd2, 0);
        do_op(2'b11, 32'd7, 32'd2, 0);
        do_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 0);
        do_op(2'b11, 32'd5, 32'd0, 0);
        do_op(2'b10, 32'd9, 32'd0, 0);
        do_op(2'b01, 32'd3, 32'd4, 5);
        mt_write(1'b0, 1'b1, 32'h00000055);
        mt_write(1'b1, 1'b1, 32'h13579BDF);

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
            if ($urandom_range(0, 5) == 0)
                mt_write(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom());
            do_op(2'($urandom_range(0, 3)), rnd_opnd(), rnd_opnd(), 0);
        end

        mt_write(1'b1, 1'b1, 32'hDEADBEEF);
        MDOp = 2'b11; A = 32'd100; B = 32'd7; start = 1'b1;
        s = cyc;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (cyc - s >= 10) break;
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_HI", HI, 0);
        chk("arst_LO", LO, 0);
        chk("arst_done", done, 0);
        m_hi = '0; m_lo = '0;
        @(negedge clk);
        rst_n = 1'b1;
        do_op(2'b01, 32'd2, 32'd3, 0);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

endmodule
